// File: rtl/psum_pool.sv
// Pooling stage behind the PE line: reads every PEB's psum rows, requantises them and applies 2x2 max-pooling.
// Pooled words are streamed to the output global buffer through a small credit-protected FIFO.
module psum_pool #(
  parameter int unsigned NUMPEB        = 16,
  parameter int unsigned LENPSUM       = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PSUM_WIDTH    = 23,
  parameter int unsigned SHIFT_WIDTH   = 5,
  parameter int unsigned OFIFO_DEPTH   = 4,
  parameter int unsigned OUT_ADDRWIDTH = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              CTRLPOOL_Sta,
  input  logic [SHIFT_WIDTH-1:0]            CFG_Shift,
  output logic                              POOLPEB_EnRd,
  output logic [$clog2(NUMPEB)-1:0]         POOLPEB_IdRd,
  output logic [$clog2(LENPSUM)-1:0]        POOLPEB_AddrRd,
  input  logic [PSUM_WIDTH*LENPSUM-1:0]     PELPOOL_Dat,
  output logic                              POOLGBF_Val,
  input  logic                              GBFPOOL_Rdy,
  output logic [OUT_ADDRWIDTH-1:0]          POOLGBF_Addr,
  output logic [DATA_WIDTH*LENPSUM/2-1:0]   POOLGBF_Dat,
  output logic                              POOL_Busy,
  output logic                              POOL_Done
);

  localparam int unsigned IdW    = $clog2(NUMPEB);
  localparam int unsigned AddrW  = $clog2(LENPSUM);
  localparam int unsigned NumOut = LENPSUM / 2;
  localparam int unsigned OutW   = DATA_WIDTH * NumOut;
  localparam int unsigned PtrW   = $clog2(OFIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned SumW   = CntW + 1;

  typedef enum logic [1:0] {StIdle, StRd, StDrain, StDone} state_e;

  state_e                   state_q, state_d;
  logic [IdW-1:0]           id_q, id_d;
  logic [AddrW-1:0]         addr_q, addr_d;
  logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
  logic [OUT_ADDRWIDTH-1:0] out_addr_q, out_addr_d;

  logic                     rd_vld_q, rd_odd_q;
  logic                     s1_vld_q, s1_odd_q;
  logic [LENPSUM-1:0][DATA_WIDTH-1:0] s1_q, s1_d, hold_q;
  logic [CntW-1:0]          inflight_q;

  logic [OFIFO_DEPTH-1:0][OutW-1:0] fifo_q;
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]          cnt_q;

  logic [SumW-1:0]          occupancy;
  logic                     credit_ok, rd_issue, even_issue, push, pop;
  logic                     last_addr, last_id;
  logic [OutW-1:0]          pooled;

  function automatic logic [DATA_WIDTH-1:0] requant(input logic [PSUM_WIDTH-1:0]  p,
                                                    input logic [SHIFT_WIDTH-1:0] sh);
    logic [PSUM_WIDTH-1:0] r;
    r = p[PSUM_WIDTH-1] ? '0 : p;
    r = r >> sh;
    return (|r[PSUM_WIDTH-1:DATA_WIDTH]) ? '1 : r[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // A pair is only started when its pooled word is guaranteed a FIFO slot.
  assign occupancy  = SumW'(cnt_q) + SumW'(inflight_q);
  assign credit_ok  = occupancy < SumW'(OFIFO_DEPTH);
  assign rd_issue   = (state_q == StRd) && (addr_q[0] || credit_ok);
  assign even_issue = rd_issue && !addr_q[0];
  assign last_addr  = addr_q == AddrW'(LENPSUM - 1);
  assign last_id    = id_q == IdW'(NUMPEB - 1);
  assign push       = s1_vld_q && s1_odd_q;
  assign pop        = (cnt_q != '0) && GBFPOOL_Rdy;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    out_addr_d = out_addr_q;
    unique case (state_q)
      StIdle: begin
        if (CTRLPOOL_Sta) begin
          state_d    = StRd;
          id_d       = '0;
          addr_d     = '0;
          shift_d    = CFG_Shift;
          out_addr_d = '0;
        end
      end
      StRd: begin
        if (rd_issue) begin
          if (last_addr) begin
            addr_d = '0;
            id_d   = id_q + IdW'(1);
            if (last_id) state_d = StDrain;
          end else begin
            addr_d = addr_q + AddrW'(1);
          end
        end
      end
      StDrain: begin
        if ((inflight_q == '0) && ((cnt_q == '0) || ((cnt_q == CntW'(1)) && pop))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (pop) out_addr_d = out_addr_q + OUT_ADDRWIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      id_q       <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      out_addr_q <= out_addr_d;
    end
  end

  always_comb begin
    s1_d = '0;
    for (int k = 0; k < LENPSUM; k++) begin
      s1_d[k] = requant(PELPOOL_Dat[k*PSUM_WIDTH +: PSUM_WIDTH], shift_q);
    end
  end

  always_comb begin
    pooled = '0;
    for (int j = 0; j < NumOut; j++) begin
      pooled[j*DATA_WIDTH +: DATA_WIDTH] = max2(max2(hold_q[2*j], hold_q[2*j+1]),
                                                max2(s1_q[2*j], s1_q[2*j+1]));
    end
  end

  // Read data returns one cycle after the strobe; stage 1 registers the lane ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_odd_q   <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_odd_q   <= 1'b0;
      s1_q       <= '0;
      hold_q     <= '0;
      inflight_q <= '0;
    end else begin
      rd_vld_q <= rd_issue;
      rd_odd_q <= addr_q[0];
      s1_vld_q <= rd_vld_q;
      s1_odd_q <= rd_odd_q;
      if (rd_vld_q) s1_q <= s1_d;
      if (s1_vld_q && !s1_odd_q) hold_q <= s1_q;
      case ({even_issue, push})
        2'b10:   inflight_q <= inflight_q + CntW'(1);
        2'b01:   inflight_q <= inflight_q - CntW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= pooled;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: ;
      endcase
    end
  end

  assign POOLPEB_EnRd   = rd_issue;
  assign POOLPEB_IdRd   = id_q;
  assign POOLPEB_AddrRd = addr_q;
  assign POOLGBF_Val    = cnt_q != '0;
  assign POOLGBF_Dat    = fifo_q[rd_ptr_q];
  assign POOLGBF_Addr   = out_addr_q;
  assign POOL_Busy      = (state_q == StRd) || (state_q == StDrain);
  assign POOL_Done      = state_q == StDone;

endmodule

// File: tb/tb_psum_pool.sv
// Directed bench for psum_pool: PEL read-port responder, output-stream monitor and frame scenarios.
// Pooled words are compared either with hand-computed constants or a small pooling model.
module tb_psum_pool;

  localparam int NumPeb   = 16;
  localparam int LenPsum  = 16;
  localparam int PsumW    = 23;
  localparam int Depth    = 4;
  localparam int Pairs    = LenPsum / 2;
  localparam int NumWords = NumPeb * Pairs;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     sta = 1'b0;
  logic [4:0]               cfg_shift = '0;
  logic                     en_rd;
  logic [3:0]               id_rd, addr_rd;
  logic [PsumW*LenPsum-1:0] pel_dat = '0;
  logic                     gbf_val;
  logic                     gbf_rdy = 1'b0;
  logic [6:0]               gbf_addr;
  logic [63:0]              gbf_dat;
  logic                     busy, done;

  int          psum_mem [NumPeb][LenPsum][LenPsum];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, widx = 0, pairs_issued = 0, max_out = 0;
  int          done_cnt = 0, last_xfer_cyc = 0, shift_exp = 0, rdy_mode = 1;
  bit          const_en = 1'b0;
  logic [63:0] const_word = '0;

  psum_pool dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .CTRLPOOL_Sta  (sta),
    .CFG_Shift     (cfg_shift),
    .POOLPEB_EnRd  (en_rd),
    .POOLPEB_IdRd  (id_rd),
    .POOLPEB_AddrRd(addr_rd),
    .PELPOOL_Dat   (pel_dat),
    .POOLGBF_Val   (gbf_val),
    .GBFPOOL_Rdy   (gbf_rdy),
    .POOLGBF_Addr  (gbf_addr),
    .POOLGBF_Dat   (gbf_dat),
    .POOL_Busy     (busy),
    .POOL_Done     (done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] q_ref(input int p, input int sh);
    int v;
    if (p < 0) return 8'd0;
    if (sh >= PsumW) return 8'd0;
    v = p >> sh;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic logic [63:0] model_word(input int w, input int sh);
    logic [63:0] res;
    logic [7:0]  m, v;
    int id, p;
    id  = w / Pairs;
    p   = w % Pairs;
    res = '0;
    for (int j = 0; j < Pairs; j++) begin
      m = 8'd0;
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 2; c++) begin
          v = q_ref(psum_mem[id][2*p+r][2*j+c], sh);
          if (v > m) m = v;
        end
      end
      res[j*8 +: 8] = m;
    end
    return res;
  endfunction

  function automatic logic [PsumW*LenPsum-1:0] build_vec(input logic [3:0] id, input logic [3:0] a);
    logic [PsumW*LenPsum-1:0] v;
    v = '0;
    for (int k = 0; k < LenPsum; k++) v[k*PsumW +: PsumW] = PsumW'(psum_mem[id][a][k]);
    return v;
  endfunction

  // PEL responder: data for a strobed read appears on the next cycle.
  initial forever begin
    @(posedge clk);
    if (en_rd) pel_dat <= build_vec(id_rd, addr_rd);
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       gbf_rdy = 1'b0;
      1:       gbf_rdy = 1'b1;
      default: gbf_rdy = ($urandom_range(0, 99) < 65);
    endcase
  end

  // Output monitor; a transfer seen here completes at the following rising edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (en_rd && !addr_rd[0]) pairs_issued++;
      if (pairs_issued - widx > max_out) max_out = pairs_issued - widx;
      if (gbf_val && gbf_rdy) begin
        check("gbf_addr", 64'(gbf_addr), 64'(widx % 128));
        check("gbf_dat", gbf_dat, const_en ? const_word : model_word(widx, shift_exp));
        widx++;
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_lat", 64'(cyc), 64'(last_xfer_cyc + 1));
        check("done_words", 64'(widx), 64'(NumWords));
      end
    end
  end

  task automatic fill_const(input int v);
    for (int i = 0; i < NumPeb; i++)
      for (int a = 0; a < LenPsum; a++)
        for (int k = 0; k < LenPsum; k++) psum_mem[i][a][k] = v;
  endtask

  // Even rows {-5, 300}, odd rows {7, 9} repeated across the lanes.
  task automatic fill_pair_pattern();
    for (int i = 0; i < NumPeb; i++)
      for (int a = 0; a < LenPsum; a++)
        for (int k = 0; k < LenPsum; k++)
          psum_mem[i][a][k] = (a % 2 == 0) ? ((k % 2 == 0) ? -5 : 300) : ((k % 2 == 0) ? 7 : 9);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NumPeb; i++)
      for (int a = 0; a < LenPsum; a++)
        for (int k = 0; k < LenPsum; k++) psum_mem[i][a][k] = i * 16 + a + k - 8;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NumPeb; i++)
      for (int a = 0; a < LenPsum; a++)
        for (int k = 0; k < LenPsum; k++) psum_mem[i][a][k] = int'($urandom_range(0, 8000)) - 2000;
  endtask

  task automatic start_frame(input int sh, input bit cen, input logic [63:0] cword);
    shift_exp    = sh;
    const_en     = cen;
    const_word   = cword;
    widx         = 0;
    pairs_issued = 0;
    max_out      = 0;
    done_cnt     = 0;
    cfg_shift    = sh[4:0];
    sta          = 1'b1;
    @(posedge clk);
    #1;
    sta = 1'b0;
    check("busy_start", 64'(busy), 64'(1));
    check("first_rd", 64'({en_rd, id_rd, addr_rd}), 64'(9'h100));
  endtask

  task automatic finish_frame();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_seen", 64'(done_cnt), 64'(1));
    check("words", 64'(widx), 64'(NumWords));
    check("busy_end", 64'({busy, done}), 64'(0));
    check("max_out", 64'(max_out <= Depth), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt), 64'(1));
  endtask

  initial begin
    int t;
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({en_rd, gbf_val, busy, done}), 64'(0));
    check("rst_rd", 64'({id_rd, addr_rd}), 64'(0));
    check("rst_gaddr", 64'(gbf_addr), 64'(0));
    check("rst_gdat", gbf_dat, 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: flat +100, shift 0
    fill_const(100);
    start_frame(0, 1'b1, {8{8'd100}});
    finish_frame();

    // T2: ReLU/shift/pool on {-5,300 | 7,9}, then saturation
    fill_pair_pattern();
    start_frame(1, 1'b1, {8{8'd150}});
    finish_frame();
    fill_const(1000);
    start_frame(0, 1'b1, {8{8'd255}});
    finish_frame();
    start_frame(23, 1'b1, 64'd0);
    finish_frame();

    // T3: back-pressure stall mid-frame
    fill_ramp();
    start_frame(0, 1'b0, 64'd0);
    t = 0;
    while (widx < 10 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stall_reach", 64'(widx >= 10), 64'(1));
    rdy_mode = 0;
    repeat (20) @(posedge clk);
    #1;
    check("stall_enrd", 64'(en_rd), 64'(0));
    check("stall_val", 64'(gbf_val), 64'(1));
    check("stall_out", 64'(pairs_issued - widx), 64'(Depth));
    rdy_mode = 1;
    finish_frame();

    // T4: second start during RD is ignored, shift stays latched
    fill_const(800);
    start_frame(3, 1'b1, {8{8'd100}});
    repeat (10) @(posedge clk);
    #1;
    cfg_shift = 5'd0;
    sta       = 1'b1;
    @(posedge clk);
    #1;
    sta = 1'b0;
    finish_frame();

    // T5: asynchronous reset mid-frame, then a clean restart
    fill_ramp();
    start_frame(0, 1'b0, 64'd0);
    repeat (40) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", 64'({en_rd, gbf_val, busy, done}), 64'(0));
    check("abort_rd", 64'({id_rd, addr_rd}), 64'(0));
    check("abort_gaddr", 64'(gbf_addr), 64'(0));
    check("abort_gdat", gbf_dat, 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_nodone", 64'(done_cnt), 64'(0));
    start_frame(1, 1'b0, 64'd0);
    finish_frame();

    // T6: random data and random ready against the model
    fill_rand();
    rdy_mode = 2;
    start_frame(int'($urandom_range(0, 6)), 1'b0, 64'd0);
    finish_frame();
    fill_rand();
    start_frame(2, 1'b0, 64'd0);
    finish_frame();
    rdy_mode = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
